change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Payout side of the vending machine. It sits downstream of the credit counter.
//  On a product select it latches the 8-bit credit and the price, then either
//  denies the sale or vends. After a vend it pays the change back as timed coin
//  pulses, largest denomination first. When finished it pulses clear_credit so
//  the credit counter returns to zero.
// PARAMETERS
//  DEN_HI       10  value of a high-denomination coin (credit units)
//  DEN_MID       5  value of a mid-denomination coin
//  DEN_LO        1  value of a low-denomination coin; must stay 1 so payout always terminates
//  PULSE_CYC     4  cycles each vend/coin output is held high (>=1)
//  GAP_CYC       2  idle cycles between successive coin pulses (>=1)
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-low reset
//  credit        in   8  current accumulated credit (binary)
//  price         in   8  price of the selected item
//  select        in   1  1-cycle request to buy at price
//  cancel        in   1  1-cycle request to refund all credit
//  vend          out  1  dispense-item strobe, PULSE_CYC cycles
//  coin_hi       out  1  eject one DEN_HI coin, PULSE_CYC cycles per coin
//  coin_mid      out  1  eject one DEN_MID coin
//  coin_lo       out  1  eject one DEN_LO coin
//  deny          out  1  1-cycle pulse: credit < price
//  busy          out  1  high in every state except IDLE
//  done          out  1  1-cycle pulse when a transaction completes
//  clear_credit  out  1  1-cycle pulse, coincident with done
//  change_left   out  8  change still to be paid out
// BEHAVIOUR
//  - Reset (reset==0 at posedge): go to IDLE and clear all outputs, counters and
//    change_left to 0. Reset also aborts any operation in progress, including a
//    half-finished coin pulse.
//  - States: IDLE, CHECK, VEND, SEL, PULSE, GAP, FIN.
//  - IDLE, select=1: latch credit into cred_r and price into price_r; go to CHECK.
//  - IDLE, cancel=1 (select=0): latch credit; change_left=credit; go to SEL (no vend).
//  - IDLE, select and cancel both 1: select wins.
//  - select and cancel are ignored while busy.
//  - CHECK, one cycle:
//      - cred_r < price_r: deny=1 for this cycle; go to IDLE. No clear_credit.
//      - otherwise: change_left = cred_r - price_r (8-bit, no underflow possible); go to VEND.
//  - VEND: vend=1 for exactly PULSE_CYC cycles; then go to SEL.
//  - SEL, one cycle, no outputs:
//      - change_left==0: go to FIN.
//      - else pick the largest of DEN_HI, DEN_MID, DEN_LO that is <= change_left; go to PULSE.
//  - PULSE: the chosen coin output is high for PULSE_CYC cycles; other coin outputs stay 0.
//    On the final cycle change_left decrements by the chosen denomination; go to GAP.
//  - GAP: all coin outputs 0 for GAP_CYC cycles; then go to SEL.
//  - FIN: done=1 and clear_credit=1 for one cycle; go to IDLE. Back-to-back select is accepted
//    the next cycle.
//  - Credit changes after latching have no effect on the transaction in progress.
//  - At most one of vend/coin_* is high in any cycle.
//  - Latency:
//      - select to deny: 2 cycles.
//      - select to vend rising: 2 cycles.
//      - price==credit: vend, then SEL, then FIN; no coin pulses.
//  - price==0 with select behaves as a vend that refunds all credit.
//  - credit==0 with cancel: SEL then FIN, done pulse only.
// TESTING
//  1. credit=30 price=15 select -> vend 4 cyc, then coin_hi x1, coin_mid x1; done+clear_credit
//     once; change_left 15->5->0.
//  2. credit=10 price=25 select -> deny 1 cyc 2 cyc after select; no vend, no coins, no clear_credit.
//  3. credit=18 cancel -> no vend; coin_hi, coin_mid, coin_lo x3 (18=10+5+1+1+1); each coin is
//     4 cyc high then 2 cyc low.
//  4. credit=20 price=20 select -> vend only; done exactly PULSE_CYC+3 cyc after select.
//  5. select during payout, credit changes mid-payout -> ignored; payout matches latched values.
//  6. reset low during 2nd coin_hi of credit=255 price=0 -> next cycle all outputs 0, IDLE;
//     later select works.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: payout controller for the vending machine.
// Latches credit and price on a select, denies or vends, then pays change
// back as timed coin pulses (largest denomination first) and finally pulses
// clear_credit so the upstream credit counter returns to zero.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for select or cancel
//   S_CHECK | one cycle: compare latched credit against latched price
//   S_VEND  | vend strobe held for PULSE_CYC cycles
//   S_SEL   | one cycle: pick next coin, or finish when no change left
//   S_PULSE | chosen coin output held for PULSE_CYC cycles
//   S_GAP   | all coin outputs low for GAP_CYC cycles
//   S_FIN   | one cycle: done and clear_credit
module change_dispenser #(
  parameter int unsigned DEN_HI    = 10,
  parameter int unsigned DEN_MID   = 5,
  parameter int unsigned DEN_LO    = 1,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] credit,
  input  logic [7:0] price,
  input  logic       select,
  input  logic       cancel,
  output logic       vend,
  output logic       coin_hi,
  output logic       coin_mid,
  output logic       coin_lo,
  output logic       deny,
  output logic       busy,
  output logic       done,
  output logic       clear_credit,
  output logic [7:0] change_left
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_VEND, S_SEL, S_PULSE, S_GAP, S_FIN
  } state_t;

  typedef enum logic [1:0] {C_NONE, C_HI, C_MID, C_LO} coin_t;

  localparam int unsigned T_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
  localparam logic [7:0] HI_V  = 8'(DEN_HI);
  localparam logic [7:0] MID_V = 8'(DEN_MID);
  localparam logic [7:0] LO_V  = 8'(DEN_LO);

  state_t           state, state_nxt;
  coin_t            coin_r, coin_pick;
  logic [7:0]       cred_r, price_r;
  logic [7:0]       coin_val;
  logic [TMR_W-1:0] tmr;
  logic             tmr_tc;
  logic             short_credit;

  assign tmr_tc       = (tmr == '0);
  assign short_credit = (cred_r < price_r);

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state decode and Moore outputs
  always_comb begin
    state_nxt    = state;
    vend         = 1'b0;
    coin_hi      = 1'b0;
    coin_mid     = 1'b0;
    coin_lo      = 1'b0;
    done         = 1'b0;
    clear_credit = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (select)      state_nxt = S_CHECK;
        else if (cancel) state_nxt = S_SEL;
      end
      S_CHECK: begin
        if (short_credit) state_nxt = S_IDLE;
        else              state_nxt = S_VEND;
      end
      S_VEND: begin
        vend = 1'b1;
        if (tmr_tc) state_nxt = S_SEL;
      end
      S_SEL: begin
        if (change_left == 8'd0) state_nxt = S_FIN;
        else                     state_nxt = S_PULSE;
      end
      S_PULSE: begin
        coin_hi  = (coin_r == C_HI);
        coin_mid = (coin_r == C_MID);
        coin_lo  = (coin_r == C_LO);
        if (tmr_tc) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (tmr_tc) state_nxt = S_SEL;
      end
      S_FIN: begin
        done         = 1'b1;
        clear_credit = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // largest coin that still fits into the remaining change
  always_comb begin
    coin_pick = C_LO;
    if (change_left >= HI_V)       coin_pick = C_HI;
    else if (change_left >= MID_V) coin_pick = C_MID;
  end

  // value of the coin currently being paid
  always_comb begin
    coin_val = LO_V;
    case (coin_r)
      C_HI:    coin_val = HI_V;
      C_MID:   coin_val = MID_V;
      default: coin_val = LO_V;
    endcase
  end

  // pulse/gap down-counter: loaded on entry to a timed state, leaves at zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmr <= '0;
    end else if ((state_nxt == S_VEND || state_nxt == S_PULSE) && state_nxt != state) begin
      tmr <= PULSE_LD;
    end else if (state_nxt == S_GAP && state != S_GAP) begin
      tmr <= GAP_LD;
    end else if (!tmr_tc) begin
      tmr <= tmr - 1'b1;
    end
  end

  // transaction datapath; deny is registered out of the CHECK compare so it
  // lands in the cycle after CHECK, the same cycle a vend would start
  always_ff @(posedge clk) begin
    if (!reset) begin
      cred_r      <= 8'd0;
      price_r     <= 8'd0;
      change_left <= 8'd0;
      coin_r      <= C_NONE;
      deny        <= 1'b0;
    end else begin
      deny <= 1'b0;
      case (state)
        S_IDLE: begin
          if (select) begin
            cred_r  <= credit;
            price_r <= price;
          end else if (cancel) begin
            cred_r      <= credit;
            change_left <= credit;
          end
        end
        S_CHECK: begin
          if (short_credit) deny <= 1'b1;
          else              change_left <= cred_r - price_r;
        end
        S_SEL: begin
          coin_r <= coin_pick;
        end
        S_PULSE: begin
          if (tmr_tc) change_left <= change_left - coin_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with hand-computed coin sequences and
// cycle positions. Timing positions are counted with the cycle in which the
// select/cancel is driven as 0.
module tb_change_dispenser;

  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] credit, price;
  logic       select, cancel;
  logic       vend, coin_hi, coin_mid, coin_lo, deny, busy, done, clear_credit;
  logic [7:0] change_left;

  change_dispenser dut (
    .clk(clk), .reset(reset), .credit(credit), .price(price),
    .select(select), .cancel(cancel), .vend(vend), .coin_hi(coin_hi),
    .coin_mid(coin_mid), .coin_lo(coin_lo), .deny(deny), .busy(busy),
    .done(done), .clear_credit(clear_credit), .change_left(change_left)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // edge bookkeeping
  int   edge_cnt = 0;
  int   start_edge = 0;
  logic mark = 1'b0;
  logic clr_req = 1'b0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (mark) start_edge <= edge_cnt + 1;
  end

  // output monitor, sampled on the falling edge
  int   rel_now;
  logic any_coin;
  assign rel_now  = edge_cnt - start_edge + 1;
  assign any_coin = coin_hi | coin_mid | coin_lo;

  int   n_vend_cyc, vend_rel, n_hi, n_mid, n_lo, coin_rel;
  int   n_done, done_rel, n_clr, n_clr_odd, n_deny, deny_rel;
  int   n_excl, bad_w, bad_g, run_len, gap_len, n_chg;
  int   chg_log [0:31];
  logic seen_coin, prev_any, prev_vend, prev_hi, prev_mid, prev_lo;

  always @(negedge clk) begin
    if (clr_req) begin
      n_vend_cyc <= 0; vend_rel <= 0; n_hi <= 0; n_mid <= 0; n_lo <= 0;
      coin_rel <= 0; n_done <= 0; done_rel <= 0; n_clr <= 0; n_clr_odd <= 0;
      n_deny <= 0; deny_rel <= 0; n_excl <= 0; bad_w <= 0; bad_g <= 0;
      run_len <= 0; gap_len <= 0; n_chg <= 0; seen_coin <= 1'b0;
      prev_any <= 1'b0; prev_vend <= 1'b0; prev_hi <= 1'b0;
      prev_mid <= 1'b0; prev_lo <= 1'b0;
    end else begin
      prev_any  <= any_coin;
      prev_vend <= vend;
      prev_hi   <= coin_hi;
      prev_mid  <= coin_mid;
      prev_lo   <= coin_lo;
      if (vend) n_vend_cyc <= n_vend_cyc + 1;
      if (vend && !prev_vend && vend_rel == 0) vend_rel <= rel_now;
      if (coin_hi && !prev_hi)   n_hi  <= n_hi + 1;
      if (coin_mid && !prev_mid) n_mid <= n_mid + 1;
      if (coin_lo && !prev_lo)   n_lo  <= n_lo + 1;
      if (any_coin && !prev_any) begin
        if (coin_rel == 0) coin_rel <= rel_now;
        // low time between coins is the GAP state plus the one-cycle SEL pick
        if (seen_coin && gap_len != GAP_CYC + 1) bad_g <= bad_g + 1;
        seen_coin <= 1'b1;
      end
      if (!any_coin && prev_any) begin
        if (run_len != PULSE_CYC) bad_w <= bad_w + 1;
        if (n_chg < 32) chg_log[n_chg] <= int'(change_left);
        n_chg <= n_chg + 1;
      end
      run_len <= any_coin ? run_len + 1 : 0;
      gap_len <= any_coin ? 0 : gap_len + 1;
      if (done) begin
        n_done <= n_done + 1;
        if (done_rel == 0) done_rel <= rel_now;
      end
      if (clear_credit) n_clr <= n_clr + 1;
      if (clear_credit != done) n_clr_odd <= n_clr_odd + 1;
      if (deny) begin
        n_deny <= n_deny + 1;
        if (deny_rel == 0) deny_rel <= rel_now;
      end
      if (int'(vend) + int'(coin_hi) + int'(coin_mid) + int'(coin_lo) > 1)
        n_excl <= n_excl + 1;
    end
  end

  task automatic start_txn(input int cr, input int pr, input logic sel, input logic can);
    @(posedge clk); #1 clr_req = 1'b1;
    @(posedge clk); #1 clr_req = 1'b0;
    credit = 8'(cr); price = 8'(pr); select = sel; cancel = can; mark = 1'b1;
    @(posedge clk); #1 select = 1'b0; cancel = 1'b0; mark = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_txn(input string t, input int vcyc, input int hi, input int mid,
                         input int lo, input int dn, input int dn_rel);
    chk({t, "_vend_cyc"}, n_vend_cyc, vcyc);
    chk({t, "_coin_hi"}, n_hi, hi);
    chk({t, "_coin_mid"}, n_mid, mid);
    chk({t, "_coin_lo"}, n_lo, lo);
    chk({t, "_done_cnt"}, n_done, dn);
    chk({t, "_clr_cnt"}, n_clr, dn);
    if (dn > 0) chk({t, "_done_pos"}, done_rel, dn_rel);
    chk({t, "_clr_with_done"}, n_clr_odd, 0);
    chk({t, "_one_hot"}, n_excl, 0);
    chk({t, "_pulse_width"}, bad_w, 0);
    chk({t, "_gap_width"}, bad_g, 0);
    chk({t, "_idle_busy"}, int'(busy), 0);
    chk({t, "_idle_change"}, int'(change_left), 0);
  endtask

  task automatic chk_log(input string t, input int n, input int e0, input int e1,
                         input int e2, input int e3, input int e4);
    int e [5];
    e = '{e0, e1, e2, e3, e4};
    chk({t, "_chg_n"}, n_chg, n);
    for (int i = 0; i < n && i < 5; i++)
      chk($sformatf("%s_chg%0d", t, i), chg_log[i], e[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; credit = 8'd0; price = 8'd0; select = 1'b0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", int'({vend, coin_hi, coin_mid, coin_lo, deny, busy, done, clear_credit}), 0);
    chk("rst_change", int'(change_left), 0);
    reset = 1'b1;

    // 30 - 15 = 15 -> vend, then 10 + 5
    start_txn(30, 15, 1'b1, 1'b0);
    run(30);
    chk_txn("t1", PULSE_CYC, 1, 1, 0, 1, 21);
    chk("t1_vend_pos", vend_rel, 2);
    chk("t1_deny", n_deny, 0);
    chk_log("t1", 2, 5, 0, 0, 0, 0);

    // 10 < 25 -> deny only
    start_txn(10, 25, 1'b1, 1'b0);
    run(10);
    chk_txn("t2", 0, 0, 0, 0, 0, 0);
    chk("t2_deny_cnt", n_deny, 1);
    chk("t2_deny_pos", deny_rel, 2);

    // cancel with 18 -> 10 + 5 + 1 + 1 + 1, no vend
    start_txn(18, 0, 1'b0, 1'b1);
    run(45);
    chk_txn("t3", 0, 1, 1, 3, 1, 37);
    chk("t3_first_coin", coin_rel, 2);
    chk_log("t3", 5, 8, 3, 2, 1, 0);

    // exact change -> vend, SEL, FIN
    start_txn(20, 20, 1'b1, 1'b0);
    run(15);
    chk_txn("t4", PULSE_CYC, 0, 0, 0, 1, PULSE_CYC + 3);
    chk("t4_chg_n", n_chg, 0);

    // select and cancel together: select wins
    start_txn(12, 12, 1'b1, 1'b1);
    run(15);
    chk_txn("tpri", PULSE_CYC, 0, 0, 0, 1, PULSE_CYC + 3);

    // 27 - 5 = 22 -> 10 + 10 + 1 + 1; requests and credit changes mid-payout ignored
    start_txn(27, 5, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1 credit = 8'd99; price = 8'd1; select = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1 select = 1'b0; cancel = 1'b0;
    repeat (8) @(posedge clk);
    #1 cancel = 1'b1; credit = 8'd3;
    @(posedge clk);
    #1 cancel = 1'b0;
    run(40);
    chk_txn("t5", PULSE_CYC, 2, 0, 2, 1, 35);
    chk_log("t5", 4, 12, 2, 1, 0, 0);

    // 255 with price 0, reset in the middle of the second coin_hi
    start_txn(255, 0, 1'b1, 1'b0);
    for (int i = 0; i < 60 && n_hi < 2; i++) @(posedge clk);
    #1;
    chk("t6_reached_2nd_hi", n_hi, 2);
    chk("t6_mid_pulse", int'(coin_hi), 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_outputs", int'({vend, coin_hi, coin_mid, coin_lo, deny, busy, done, clear_credit}), 0);
    chk("t6_rst_change", int'(change_left), 0);
    reset = 1'b1;
    // 7 - 2 = 5 -> one mid coin after the abort
    start_txn(7, 2, 1'b1, 1'b0);
    run(25);
    chk_txn("t6b", PULSE_CYC, 0, 1, 0, 1, 14);
    chk_log("t6b", 1, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
